// File: rtl/filter_spad_loader.sv
// Fill stage for the PE filter scratchpad: streams weights into spad addresses 0..len-1 and pulses done.
// Optional build macro FILTER_LOAD_CHKSUM_EN adds a 16-bit running sum of accepted weights.
module filter_spad_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              spad_wr,
  output logic [ADDR_W-1:0] spad_addr,
  output logic [DATA_W-1:0] spad_wdata,
  output logic              busy,
`ifdef FILTER_LOAD_CHKSUM_EN
  output logic [15:0]       chksum,
`endif
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] ZERO_L  = (ADDR_W+1)'(0);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     ptr_q, ptr_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                accept_s;
  logic [ADDR_W:0]     eff_len_s;

  // Length is clamped to the spad depth so addresses can never wrap.
  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] req);
    clamp_len = (req > DEPTH_L) ? DEPTH_L : req;
  endfunction

  // Handshake and decoded status outputs.
  always_comb begin
    in_ready  = (state_q == S_LOAD);
    accept_s  = in_ready & in_valid;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    eff_len_s = clamp_len(len);
  end

  // Next-state, write pipeline and pointer logic.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    if (accept_s) begin
      wr_d    = 1'b1;
      addr_d  = ptr_q[ADDR_W-1:0];
      wdata_d = in_data;
      ptr_d   = ptr_q + ONE_L;
    end else begin
      wr_d    = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = eff_len_s;
          ptr_d   = ZERO_L;
          state_d = (eff_len_s == ZERO_L) ? S_DONE : S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        // Abort still lets a beat accepted in the same cycle land in the spad.
        if (abort) begin
          state_d = S_IDLE;
        end else if (accept_s && ((ptr_q + ONE_L) == len_q)) begin
          state_d = S_FLUSH;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_FLUSH: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and write-port registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= ZERO_L;
      ptr_q   <= ZERO_L;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign spad_wr    = wr_q;
  assign spad_addr  = addr_q;
  assign spad_wdata = wdata_q;

`ifdef FILTER_LOAD_CHKSUM_EN
  logic [15:0] chksum_q, chksum_d;

  function automatic logic [15:0] sum16(input logic [15:0] acc, input logic [DATA_W-1:0] val);
    sum16 = acc + 16'(val);
  endfunction

  // Running sum restarts on each accepted start and freezes once the load finishes.
  always_comb begin
    chksum_d = chksum_q;
    if ((state_q == S_IDLE) && start) begin
      chksum_d = 16'h0000;
    end else if (accept_s) begin
      chksum_d = sum16(chksum_q, in_data);
    end else begin
      chksum_d = chksum_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chksum_q <= 16'h0000;
    end else begin
      chksum_q <= chksum_d;
    end
  end

  assign chksum = chksum_q;
`endif

endmodule

// File: tb/tb_filter_spad_loader.sv
// Directed table-driven bench for filter_spad_loader with hand-written multi-cycle sequences.
module tb_filter_spad_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [6:0] len;
  logic       abort;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       spad_wr;
  logic [5:0] spad_addr;
  logic [7:0] spad_wdata;
  logic       busy;
  logic       done;
`ifdef FILTER_LOAD_CHKSUM_EN
  logic [15:0] chksum;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  filter_spad_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .spad_wr   (spad_wr),
    .spad_addr (spad_addr),
    .spad_wdata(spad_wdata),
    .busy      (busy),
`ifdef FILTER_LOAD_CHKSUM_EN
    .chksum    (chksum),
`endif
    .done      (done)
  );

  typedef struct {
    logic       st;
    logic [6:0] ln;
    logic       ab;
    logic       v;
    logic [7:0] d;
    logic       e_rdy;
    logic       e_wr;
    logic [5:0] e_addr;
    logic [7:0] e_wd;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic row(input logic st, input logic [6:0] ln, input logic ab, input logic v,
                     input logic [7:0] d, input logic rdy, input logic wr, input logic [5:0] addr,
                     input logic [7:0] wd, input logic bsy, input logic dn);
    vec_t r;
    r.st = st; r.ln = ln; r.ab = ab; r.v = v; r.d = d;
    r.e_rdy = rdy; r.e_wr = wr; r.e_addr = addr; r.e_wd = wd; r.e_busy = bsy; r.e_done = dn;
    vecs.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; len = 7'd0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
  endtask

  initial begin
    int writes;
    int accepts;
    bit seen_done;
    bit pre_rdy;

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 0, 32'(in_ready), 32'd0);
    chk("rst_spad_wr", 0, 32'(spad_wr), 32'd0);
    chk("rst_spad_addr", 0, 32'(spad_addr), 32'd0);
    chk("rst_spad_wdata", 0, 32'(spad_wdata), 32'd0);
    chk("rst_busy", 0, 32'(busy), 32'd0);
    chk("rst_done", 0, 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Reset asserted in the middle of a load.
    start = 1'b1; len = 7'd8; step();
    start = 1'b0; in_valid = 1'b1; in_data = 8'hA1; step();
    in_data = 8'hA2; step();
    chk("pre_rst_addr", 0, 32'(spad_addr), 32'd1);
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 0, 32'(in_ready), 32'd0);
    chk("mid_rst_spad_wr", 0, 32'(spad_wr), 32'd0);
    chk("mid_rst_spad_addr", 0, 32'(spad_addr), 32'd0);
    chk("mid_rst_spad_wdata", 0, 32'(spad_wdata), 32'd0);
    chk("mid_rst_busy", 0, 32'(busy), 32'd0);
    chk("mid_rst_done", 0, 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    //   st len ab v  d       rdy wr addr  wd     busy done
    // after reset: len=1 load writes addr 0
    row(1, 7'd1, 0, 0, 8'h00,  1, 0, 6'd0, 8'h00, 1, 0);
    row(0, 7'd0, 0, 1, 8'h99,  0, 1, 6'd0, 8'h99, 1, 0);
    row(0, 7'd0, 0, 0, 8'h00,  0, 0, 6'd0, 8'h00, 1, 1);
    row(0, 7'd0, 0, 0, 8'h00,  0, 0, 6'd0, 8'h00, 0, 0);
    // len=4, back-to-back beats
    row(1, 7'd4, 0, 0, 8'h00,  1, 0, 6'd0, 8'h00, 1, 0);
    row(0, 7'd0, 0, 1, 8'h11,  1, 1, 6'd0, 8'h11, 1, 0);
    row(0, 7'd0, 0, 1, 8'h22,  1, 1, 6'd1, 8'h22, 1, 0);
    row(0, 7'd0, 0, 1, 8'h33,  1, 1, 6'd2, 8'h33, 1, 0);
    row(0, 7'd0, 0, 1, 8'h44,  0, 1, 6'd3, 8'h44, 1, 0);
    row(0, 7'd0, 0, 0, 8'h00,  0, 0, 6'd3, 8'h00, 1, 1);
    row(0, 7'd0, 0, 0, 8'h00,  0, 0, 6'd3, 8'h00, 0, 0);
    // len=3 with gaps in in_valid
    row(1, 7'd3, 0, 0, 8'h00,  1, 0, 6'd3, 8'h00, 1, 0);
    row(0, 7'd0, 0, 1, 8'hAA,  1, 1, 6'd0, 8'hAA, 1, 0);
    row(0, 7'd0, 0, 0, 8'h5A,  1, 0, 6'd0, 8'h00, 1, 0);
    row(0, 7'd0, 0, 0, 8'h5A,  1, 0, 6'd0, 8'h00, 1, 0);
    row(0, 7'd0, 0, 1, 8'hBB,  1, 1, 6'd1, 8'hBB, 1, 0);
    row(0, 7'd0, 0, 0, 8'h5A,  1, 0, 6'd1, 8'h00, 1, 0);
    row(0, 7'd0, 0, 1, 8'hCC,  0, 1, 6'd2, 8'hCC, 1, 0);
    row(0, 7'd0, 0, 0, 8'h00,  0, 0, 6'd2, 8'h00, 1, 1);
    row(0, 7'd0, 0, 0, 8'h00,  0, 0, 6'd2, 8'h00, 0, 0);
    // len=0 goes straight to DONE
    row(1, 7'd0, 0, 1, 8'hEE,  0, 0, 6'd2, 8'h00, 1, 1);
    row(0, 7'd0, 0, 0, 8'h00,  0, 0, 6'd2, 8'h00, 0, 0);
    // start ignored while loading; valid in FLUSH not accepted
    row(1, 7'd2, 0, 0, 8'h00,  1, 0, 6'd2, 8'h00, 1, 0);
    row(1, 7'd0, 0, 1, 8'h31,  1, 1, 6'd0, 8'h31, 1, 0);
    row(0, 7'd0, 0, 1, 8'h32,  0, 1, 6'd1, 8'h32, 1, 0);
    row(0, 7'd0, 0, 1, 8'h33,  0, 0, 6'd1, 8'h00, 1, 1);
    row(0, 7'd0, 0, 0, 8'h00,  0, 0, 6'd1, 8'h00, 0, 0);
    // len=8, abort after the 2nd accept, then len=1 restart
    row(1, 7'd8, 0, 0, 8'h00,  1, 0, 6'd1, 8'h00, 1, 0);
    row(0, 7'd0, 0, 1, 8'hD1,  1, 1, 6'd0, 8'hD1, 1, 0);
    row(0, 7'd0, 0, 1, 8'hD2,  1, 1, 6'd1, 8'hD2, 1, 0);
    row(0, 7'd0, 1, 0, 8'h00,  0, 0, 6'd1, 8'h00, 0, 0);
    row(0, 7'd0, 0, 1, 8'hD9,  0, 0, 6'd1, 8'h00, 0, 0);
    row(1, 7'd1, 0, 0, 8'h00,  1, 0, 6'd1, 8'h00, 1, 0);
    row(0, 7'd0, 0, 1, 8'h77,  0, 1, 6'd0, 8'h77, 1, 0);
    row(0, 7'd0, 0, 0, 8'h00,  0, 0, 6'd0, 8'h00, 1, 1);
    row(0, 7'd0, 0, 0, 8'h00,  0, 0, 6'd0, 8'h00, 0, 0);
    // start+abort together in IDLE: start wins; abort with a same-cycle beat still writes it
    row(1, 7'd8, 1, 0, 8'h00,  1, 0, 6'd0, 8'h00, 1, 0);
    row(0, 7'd0, 0, 1, 8'hE1,  1, 1, 6'd0, 8'hE1, 1, 0);
    row(0, 7'd0, 1, 1, 8'hE2,  0, 1, 6'd1, 8'hE2, 0, 0);
    row(0, 7'd0, 0, 1, 8'hE3,  0, 0, 6'd1, 8'h00, 0, 0);
    // abort in FLUSH suppresses done
    row(1, 7'd1, 0, 0, 8'h00,  1, 0, 6'd1, 8'h00, 1, 0);
    row(0, 7'd0, 0, 1, 8'h55,  0, 1, 6'd0, 8'h55, 1, 0);
    row(0, 7'd0, 1, 0, 8'h00,  0, 0, 6'd0, 8'h00, 0, 0);
    row(0, 7'd0, 0, 0, 8'h00,  0, 0, 6'd0, 8'h00, 0, 0);

    foreach (vecs[i]) begin
      start = vecs[i].st; len = vecs[i].ln; abort = vecs[i].ab;
      in_valid = vecs[i].v; in_data = vecs[i].d;
      step();
      chk("in_ready", i, 32'(in_ready), 32'(vecs[i].e_rdy));
      chk("spad_wr", i, 32'(spad_wr), 32'(vecs[i].e_wr));
      chk("spad_addr", i, 32'(spad_addr), 32'(vecs[i].e_addr));
      if (vecs[i].e_wr) chk("spad_wdata", i, 32'(spad_wdata), 32'(vecs[i].e_wd));
      chk("busy", i, 32'(busy), 32'(vecs[i].e_busy));
      chk("done", i, 32'(done), 32'(vecs[i].e_done));
    end
    idle_inputs();

    // len=100 clamps to 64 writes at addr 0..63
    start = 1'b1; len = 7'd100; step();
    start = 1'b0;
    writes = 0; accepts = 0; seen_done = 1'b0;
    for (int cyc = 0; cyc < 80 && !seen_done; cyc++) begin
      in_valid = 1'b1;
      in_data = 8'(cyc);
      pre_rdy = in_ready;
      @(posedge clk);
      if (pre_rdy) accepts++;
      #1;
      if (spad_wr) begin
        chk("clamp_addr", writes, 32'(spad_addr), 32'(writes));
        chk("clamp_wdata", writes, 32'(spad_wdata), 32'(writes));
        writes++;
      end
      if (done) seen_done = 1'b1;
    end
    idle_inputs();
    chk("clamp_writes", 0, 32'(writes), 32'd64);
    chk("clamp_accepts", 0, 32'(accepts), 32'd64);
    chk("clamp_done_seen", 0, 32'(seen_done), 32'd1);
    step();
    chk("clamp_idle_busy", 0, 32'(busy), 32'd0);

`ifdef FILTER_LOAD_CHKSUM_EN
    // 64 x 0xFF sums to 0x3FC0; a new start clears it
    start = 1'b1; len = 7'd64; step();
    start = 1'b0;
    seen_done = 1'b0;
    for (int cyc = 0; cyc < 80 && !seen_done; cyc++) begin
      in_valid = 1'b1; in_data = 8'hFF;
      step();
      if (done) begin
        seen_done = 1'b1;
        chk("chksum_at_done", cyc, 32'(chksum), 32'h3FC0);
      end
    end
    idle_inputs();
    chk("chksum_done_seen", 0, 32'(seen_done), 32'd1);
    step();
    chk("chksum_stable", 0, 32'(chksum), 32'h3FC0);
    start = 1'b1; len = 7'd1; step();
    start = 1'b0;
    chk("chksum_cleared", 0, 32'(chksum), 32'h0000);
    in_valid = 1'b1; in_data = 8'h12; step();
    idle_inputs();
    step();
    chk("chksum_single", 0, 32'(chksum), 32'h0012);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
